e203_exu_wbck_arb: RTL and testbench
====================================

Name: e203_exu_wbck_arb

Overview:
- Write-back stage directly downstream of the regular ALU.
- Arbitrates the ALU write-back stream against the long-pipe (LSU/MulDiv) write-back stream into one regfile write stream.
- Buffers the granted result in a 2-entry output FIFO, so the regfile write path is registered and decoupled from ALU timing.
- Anti-starvation counter prevents long-pipe traffic from locking out the ALU indefinitely.

Parameters:
XLEN, 32, data width (matches E203_XLEN)
RFIDX_W, 5, register index width
STARVE_MAX, 4, consecutive ALU denials after which ALU gets priority (range 1..15)

Ports:
clk  input  1  core clock
rst_n  input  1  reset, asynchronous, active-low
alu_wbck_i_valid  input  1  ALU result valid
alu_wbck_i_ready  output  1  ALU result accepted
alu_wbck_i_wdat  input  XLEN  ALU result data
alu_wbck_i_rdidx  input  RFIDX_W  destination register
alu_wbck_i_rdwen  input  1  instruction writes rd
alu_wbck_i_err  input  1  ecall/ebreak/wfi/exception; suppress write
longp_wbck_i_valid  input  1  long-pipe result valid
longp_wbck_i_ready  output  1  long-pipe result accepted
longp_wbck_i_wdat  input  XLEN  long-pipe result data
longp_wbck_i_rdidx  input  RFIDX_W  destination register
longp_wbck_i_err  input  1  long-pipe error; suppress write
rf_wbck_o_valid  output  1  regfile write pending
rf_wbck_o_ready  input  1  regfile write taken
rf_wbck_o_wdat  output  XLEN  write data
rf_wbck_o_rdidx  output  RFIDX_W  write index
rf_wbck_o_src  output  1  0 = ALU, 1 = long-pipe (debug/commit tracking)

Behaviour:
- Reset (async on rst_n low):
  - FIFO count = 0, pointers = 0, starve counter = 0.
  - rf_wbck_o_valid = 0; rf_wbck_o_wdat, rf_wbck_o_rdidx, rf_wbck_o_src = 0.
  - Both input readies = 0 only while rst_n is low.
- Reset mid-operation discards all buffered entries. No partial write is emitted.
- Space is defined as FIFO count < 2. Pop and push in the same cycle when count == 2 are not chained: a full FIFO refuses input even if the output pops in that cycle.
- Grant, evaluated each cycle when space exists:
  - Default priority: long-pipe first (older instruction).
  - If the starve counter == STARVE_MAX and alu_wbck_i_valid, ALU wins instead.
  - Exactly one source is granted per cycle. The granted source's ready = 1; the other's ready = 0.
- Drop rule: a granted ALU item with err = 1 or rdwen = 0, or a granted long-pipe item with err = 1, is handshaken (ready = 1) but not enqueued.
  - rdidx == 0 is enqueued normally; the regfile ignores x0.
- Starve counter:
  - Increments (saturating at STARVE_MAX) when alu_wbck_i_valid = 1 and long-pipe is granted.
  - Clears when the ALU is granted or alu_wbck_i_valid = 0.
  - Holds when there is no space.
- Latency: an item accepted in cycle N appears on rf_wbck_o_* in cycle N+1 if the FIFO was empty. Output is the FIFO head, driven from flops.
- Output handshake: pop on rf_wbck_o_valid & rf_wbck_o_ready. The head is held stable while valid & !ready.
- Simultaneous push and pop with count == 1: count stays 1 and the new entry becomes head next cycle.
- Ordering: strict FIFO order of acceptance.
- Pointers are 1-bit and wrap 1 -> 0.

Decomposition:
- Shared package/defines: XLEN and RFIDX_W (reuse the E203_XLEN and E203_RFIDX_WIDTH defines), plus a wbck source encoding constant (SRC_ALU = 0, SRC_LONGP = 1).
- One natural sub-module, e203_exu_wbck_fifo: 2-entry generic valid/ready FIFO with async active-low reset, width = XLEN + RFIDX_W + 1.
- The arbiter and starve counter live in the top module.

Test Plan:
- ALU only: valid with wdat = 0x12345678, rdidx = 5, rdwen = 1, out_ready = 1 -> rf_wbck_o_valid one cycle later with 0x12345678 / 5 / src = 0; a back-to-back stream gives 1 item per cycle.
- Both sources valid every cycle with STARVE_MAX = 4 -> grants are L, L, L, L, A, L, L, L, L, A...; output src sequence matches; no item lost or reordered.
- Error/suppressed writes: ALU err = 1, then ALU rdwen = 0, then long-pipe err = 1 -> all three handshaken; rf_wbck_o_valid stays 0.
- Backpressure: out_ready = 0 while pushing 3 ALU items -> first two accepted, alu_wbck_i_ready = 0 on the third; head stays stable. Raising out_ready -> items drain in order and the third is accepted only after count < 2.
- Push/pop overlap: count = 1 with a simultaneous pop and new push -> count stays 1 and the output shows the new item next cycle.
- Async reset: assert rst_n low mid-cycle with 2 entries buffered -> rf_wbck_o_valid drops immediately; after release both readies return and no stale data is emitted.

Source files
------------

// File: rtl/e203_exu_wbck_arb_pkg.sv
// Shared widths and encodings for the EXU write-back arbiter slice.
`ifndef E203_XLEN
`define E203_XLEN 32
`endif

`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif

package e203_exu_wbck_arb_pkg;

   localparam int XLEN = `E203_XLEN;

   localparam int RFIDX_W = `E203_RFIDX_WIDTH;

   // Width of the starvation counter; STARVE_MAX must fit in it (1..15).
   localparam int STARVE_CNT_W = 4;

   // Which pipe produced a write-back entry.
   typedef enum logic {
      SRC_ALU   = 1'b0,
      SRC_LONGP = 1'b1
   } wbck_src_e;

   // Saturating increment used by the anti-starvation counter.
   function automatic logic [STARVE_CNT_W-1:0] starve_inc(
      input logic [STARVE_CNT_W-1:0] cnt,
      input logic [STARVE_CNT_W-1:0] max_cnt
   );
      return (cnt >= max_cnt) ? max_cnt : cnt + STARVE_CNT_W'(1);
   endfunction

endpackage

// File: rtl/e203_exu_wbck_arb_if.sv
// Handshake bundle for the ALU, long-pipe and regfile write-back channels.
interface e203_exu_wbck_arb_if
   import e203_exu_wbck_arb_pkg::*;
#(
   parameter int XLEN    = e203_exu_wbck_arb_pkg::XLEN,
   parameter int RFIDX_W = e203_exu_wbck_arb_pkg::RFIDX_W
);

   logic               alu_wbck_i_valid;
   logic               alu_wbck_i_ready;
   logic [XLEN-1:0]    alu_wbck_i_wdat;
   logic [RFIDX_W-1:0] alu_wbck_i_rdidx;
   logic               alu_wbck_i_rdwen;
   logic               alu_wbck_i_err;

   logic               longp_wbck_i_valid;
   logic               longp_wbck_i_ready;
   logic [XLEN-1:0]    longp_wbck_i_wdat;
   logic [RFIDX_W-1:0] longp_wbck_i_rdidx;
   logic               longp_wbck_i_err;

   logic               rf_wbck_o_valid;
   logic               rf_wbck_o_ready;
   logic [XLEN-1:0]    rf_wbck_o_wdat;
   logic [RFIDX_W-1:0] rf_wbck_o_rdidx;
   logic               rf_wbck_o_src;

   // Producer side: drives both write-back sources and the regfile ready.
   modport master (
      output alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
             alu_wbck_i_rdwen, alu_wbck_i_err,
      input  alu_wbck_i_ready,
      output longp_wbck_i_valid, longp_wbck_i_wdat, longp_wbck_i_rdidx,
             longp_wbck_i_err,
      input  longp_wbck_i_ready,
      input  rf_wbck_o_valid, rf_wbck_o_wdat, rf_wbck_o_rdidx, rf_wbck_o_src,
      output rf_wbck_o_ready
   );

   // Arbiter side.
   modport slave (
      input  alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
             alu_wbck_i_rdwen, alu_wbck_i_err,
      output alu_wbck_i_ready,
      input  longp_wbck_i_valid, longp_wbck_i_wdat, longp_wbck_i_rdidx,
             longp_wbck_i_err,
      output longp_wbck_i_ready,
      output rf_wbck_o_valid, rf_wbck_o_wdat, rf_wbck_o_rdidx, rf_wbck_o_src,
      input  rf_wbck_o_ready
   );

endinterface

// File: rtl/e203_exu_wbck_fifo.sv
// Two-entry valid/ready FIFO; the head is read straight out of the storage flops.
// A full FIFO refuses input even when it pops in the same cycle.
module e203_exu_wbck_fifo
   import e203_exu_wbck_arb_pkg::*;
#(
   parameter int WIDTH = 38
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [WIDTH-1:0] i_dat,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [WIDTH-1:0] o_dat
);

   logic [WIDTH-1:0] mem [2];
   logic             wptr;
   logic             rptr;
   logic [1:0]       cnt;
   logic             push;
   logic             pop;

   assign i_ready = (cnt != 2'd2);
   assign o_valid = (cnt != 2'd0);
   assign o_dat   = mem[rptr];
   assign push    = i_valid & i_ready;
   assign pop     = o_valid & o_ready;

   // Pointer and occupancy bookkeeping; simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= 1'b0;
         rptr <= 1'b0;
         cnt  <= 2'd0;
      end else begin
         if (push) wptr <= ~wptr;
         if (pop)  rptr <= ~rptr;
         case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Entry storage; cleared on reset so the outputs read zero until the first write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
      end else if (push) begin
         mem[wptr] <= i_dat;
      end
   end

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// Write-back arbiter: merges the ALU and long-pipe result streams into one
// registered regfile write stream, with an anti-starvation guard for the ALU.
module e203_exu_wbck_arb
   import e203_exu_wbck_arb_pkg::*;
#(
   parameter int XLEN       = e203_exu_wbck_arb_pkg::XLEN,
   parameter int RFIDX_W    = e203_exu_wbck_arb_pkg::RFIDX_W,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   e203_exu_wbck_arb_if.slave  wbck
);

   localparam int ENT_W = XLEN + RFIDX_W + 1;
   localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

   logic                    fifo_i_ready;
   logic                    fifo_i_valid;
   logic [ENT_W-1:0]        fifo_i_dat;
   logic [ENT_W-1:0]        fifo_o_dat;
   logic                    space;
   logic                    alu_pri;
   logic                    grant_alu;
   logic                    grant_longp;
   logic [STARVE_CNT_W-1:0] starve_cnt;

   // Readies are forced low while reset is held, even though the empty FIFO has room.
   assign space   = fifo_i_ready & rst_n;
   assign alu_pri = wbck.alu_wbck_i_valid & (starve_cnt == STARVE_LIM);

   // Pick at most one source: long-pipe by default, ALU once it has been denied long enough.
   always_comb begin
      grant_alu   = 1'b0;
      grant_longp = 1'b0;
      if (space) begin
         if (alu_pri)                      grant_alu   = 1'b1;
         else if (wbck.longp_wbck_i_valid) grant_longp = 1'b1;
         else if (wbck.alu_wbck_i_valid)   grant_alu   = 1'b1;
      end
   end

   assign wbck.alu_wbck_i_ready   = grant_alu;
   assign wbck.longp_wbck_i_ready = grant_longp;

   // Suppressed writes are handshaken but never reach the FIFO.
   always_comb begin
      fifo_i_valid = 1'b0;
      fifo_i_dat   = '0;
      if (grant_alu) begin
         fifo_i_valid = wbck.alu_wbck_i_rdwen & ~wbck.alu_wbck_i_err;
         fifo_i_dat   = {SRC_ALU, wbck.alu_wbck_i_rdidx, wbck.alu_wbck_i_wdat};
      end else if (grant_longp) begin
         fifo_i_valid = ~wbck.longp_wbck_i_err;
         fifo_i_dat   = {SRC_LONGP, wbck.longp_wbck_i_rdidx, wbck.longp_wbck_i_wdat};
      end
   end

   // Count consecutive cycles where a waiting ALU result lost to the long-pipe; frozen while full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (space) begin
         if (wbck.alu_wbck_i_valid & grant_longp)
            starve_cnt <= starve_inc(starve_cnt, STARVE_LIM);
         else
            starve_cnt <= '0;
      end
   end

   e203_exu_wbck_fifo #(
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (fifo_i_valid),
      .i_ready (fifo_i_ready),
      .i_dat   (fifo_i_dat),
      .o_valid (wbck.rf_wbck_o_valid),
      .o_ready (wbck.rf_wbck_o_ready),
      .o_dat   (fifo_o_dat)
   );

   assign {wbck.rf_wbck_o_src, wbck.rf_wbck_o_rdidx, wbck.rf_wbck_o_wdat} = fifo_o_dat;

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Scoreboard bench for the write-back arbiter: the stimulus side predicts the grant
// and queues the expected regfile write; a monitor compares and retires the queue head.
module tb_e203_exu_wbck_arb;

   localparam int STARVE_MAX = 4;
   localparam int W_NONE  = 0;
   localparam int W_ALU   = 1;
   localparam int W_LONGP = 2;

   typedef struct {
      logic [31:0] wdat;
      logic [4:0]  rdidx;
      logic        src;
   } exp_t;

   logic clk;
   logic rst_n;
   bit   in_reset;
   bit   mon_en;
   int   checks;
   int   failures;
   int   denials;
   logic last_alu_ready;
   exp_t exp_q[$];

   e203_exu_wbck_arb_if wbck_if ();

   e203_exu_wbck_arb #(
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wbck  (wbck_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: drive at negedge, predict the grant from the queue occupancy and the
   // count of consecutive ALU denials, then commit the expected write after the edge.
   task automatic applyStimulus(input logic av, input logic [31:0] ad, input logic [4:0] ai,
                                input logic awen, input logic aerr,
                                input logic lv, input logic [31:0] ld, input logic [4:0] li,
                                input logic lerr, input logic ordy);
      int   winner;
      bit   enq;
      exp_t item;
      @(negedge clk);
      wbck_if.alu_wbck_i_valid   = av;
      wbck_if.alu_wbck_i_wdat    = ad;
      wbck_if.alu_wbck_i_rdidx   = ai;
      wbck_if.alu_wbck_i_rdwen   = awen;
      wbck_if.alu_wbck_i_err     = aerr;
      wbck_if.longp_wbck_i_valid = lv;
      wbck_if.longp_wbck_i_wdat  = ld;
      wbck_if.longp_wbck_i_rdidx = li;
      wbck_if.longp_wbck_i_err   = lerr;
      wbck_if.rf_wbck_o_ready    = ordy;
      #2;
      winner = W_NONE;
      if (exp_q.size() < 2) begin
         if (av && denials == STARVE_MAX) winner = W_ALU;
         else if (lv)                     winner = W_LONGP;
         else if (av)                     winner = W_ALU;
         if (av && winner == W_LONGP) denials = (denials < STARVE_MAX) ? denials + 1 : STARVE_MAX;
         else                         denials = 0;
      end
      last_alu_ready = wbck_if.alu_wbck_i_ready;
      checkOutput("alu_ready", {31'd0, wbck_if.alu_wbck_i_ready}, {31'd0, winner == W_ALU});
      checkOutput("longp_ready", {31'd0, wbck_if.longp_wbck_i_ready}, {31'd0, winner == W_LONGP});
      enq = 1'b0;
      if (winner == W_ALU && awen && !aerr) begin
         enq = 1'b1; item.wdat = ad; item.rdidx = ai; item.src = 1'b0;
      end else if (winner == W_LONGP && !lerr) begin
         enq = 1'b1; item.wdat = ld; item.rdidx = li; item.src = 1'b1;
      end
      @(posedge clk);
      if (enq) exp_q.push_back(item);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, $urandom(), 5'($urandom()), 1'b1, 1'b0,
                       1'b0, $urandom(), 5'($urandom()), 1'b0, 1'b1);
   endtask

   task automatic aluItem(input logic [31:0] d, input logic [4:0] r, input logic ordy);
      applyStimulus(1'b1, d, r, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, ordy);
   endtask

   // Monitor: just before each rising edge, compare the regfile port against the queue head.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (mon_en && !in_reset) begin
            checkOutput("rf_valid", {31'd0, wbck_if.rf_wbck_o_valid}, {31'd0, exp_q.size() > 0});
            if (exp_q.size() > 0) begin
               checkOutput("rf_wdat", wbck_if.rf_wbck_o_wdat, exp_q[0].wdat);
               checkOutput("rf_rdidx", {27'd0, wbck_if.rf_wbck_o_rdidx}, {27'd0, exp_q[0].rdidx});
               checkOutput("rf_src", {31'd0, wbck_if.rf_wbck_o_src}, {31'd0, exp_q[0].src});
               if (wbck_if.rf_wbck_o_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      checks = 0; failures = 0; denials = 0;
      in_reset = 1'b1; mon_en = 1'b0; rst_n = 1'b0;
      wbck_if.alu_wbck_i_valid = 1'b1;   wbck_if.alu_wbck_i_wdat = 32'hdead_beef;
      wbck_if.alu_wbck_i_rdidx = 5'd3;   wbck_if.alu_wbck_i_rdwen = 1'b1;
      wbck_if.alu_wbck_i_err = 1'b0;     wbck_if.longp_wbck_i_valid = 1'b1;
      wbck_if.longp_wbck_i_wdat = 32'h1; wbck_if.longp_wbck_i_rdidx = 5'd4;
      wbck_if.longp_wbck_i_err = 1'b0;   wbck_if.rf_wbck_o_ready = 1'b1;

      // Reset state with both sources requesting.
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_rf_valid", {31'd0, wbck_if.rf_wbck_o_valid}, 32'd0);
      checkOutput("rst_rf_wdat", wbck_if.rf_wbck_o_wdat, 32'd0);
      checkOutput("rst_rf_rdidx", {27'd0, wbck_if.rf_wbck_o_rdidx}, 32'd0);
      checkOutput("rst_rf_src", {31'd0, wbck_if.rf_wbck_o_src}, 32'd0);
      checkOutput("rst_alu_ready", {31'd0, wbck_if.alu_wbck_i_ready}, 32'd0);
      checkOutput("rst_longp_ready", {31'd0, wbck_if.longp_wbck_i_ready}, 32'd0);
      @(negedge clk);
      #1;
      wbck_if.alu_wbck_i_valid = 1'b0; wbck_if.longp_wbck_i_valid = 1'b0;
      rst_n = 1'b1; in_reset = 1'b0; mon_en = 1'b1;

      $display("[TB] ALU-only single item and back-to-back stream");
      aluItem(32'h1234_5678, 5'd5, 1'b1);
      for (int i = 0; i < 6; i++) aluItem($urandom(), 5'($urandom()), 1'b1);
      idleCycles(2);

      $display("[TB] both sources contending");
      idleCycles(1);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, 32'hA000_0000 + k, 5'(k + 1), 1'b1, 1'b0,
                       1'b1, 32'hB000_0000 + k, 5'(k + 11), 1'b0, 1'b1);
         checkOutput("starve_pattern", {31'd0, last_alu_ready}, {31'd0, (k % 5) == 4});
      end
      idleCycles(2);

      $display("[TB] suppressed writes");
      applyStimulus(1'b1, 32'h1111_1111, 5'd1, 1'b1, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h2222_2222, 5'd2, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h3333_3333, 5'd3, 1'b1, 1'b1);
      idleCycles(2);

      $display("[TB] backpressure with a full FIFO");
      aluItem(32'hC000_0001, 5'd7, 1'b0);
      aluItem(32'hC000_0002, 5'd8, 1'b0);
      aluItem(32'hC000_0003, 5'd9, 1'b0);
      checkOutput("bp_third_refused", {31'd0, last_alu_ready}, 32'd0);
      aluItem(32'hC000_0003, 5'd9, 1'b1);
      checkOutput("bp_no_chain", {31'd0, last_alu_ready}, 32'd0);
      aluItem(32'hC000_0003, 5'd9, 1'b1);
      checkOutput("bp_accept_after_pop", {31'd0, last_alu_ready}, 32'd1);
      idleCycles(3);

      $display("[TB] push and pop overlap at one entry");
      aluItem(32'hD000_0001, 5'd10, 1'b0);
      aluItem(32'hD000_0002, 5'd11, 1'b1);
      idleCycles(2);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++)
         applyStimulus($urandom_range(0, 99) < 60, $urandom(), 5'($urandom()),
                       $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 99) < 50, $urandom(), 5'($urandom()),
                       $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 70);
      idleCycles(3);

      $display("[TB] asynchronous reset with two buffered entries");
      aluItem(32'hE000_0001, 5'd12, 1'b0);
      aluItem(32'hE000_0002, 5'd13, 1'b0);
      @(negedge clk);
      wbck_if.alu_wbck_i_valid = 1'b1; wbck_if.longp_wbck_i_valid = 1'b1;
      wbck_if.rf_wbck_o_ready = 1'b0;
      #1;
      rst_n = 1'b0; in_reset = 1'b1;
      #1;
      checkOutput("mid_rst_rf_valid", {31'd0, wbck_if.rf_wbck_o_valid}, 32'd0);
      checkOutput("mid_rst_alu_ready", {31'd0, wbck_if.alu_wbck_i_ready}, 32'd0);
      checkOutput("mid_rst_longp_ready", {31'd0, wbck_if.longp_wbck_i_ready}, 32'd0);
      exp_q.delete();
      denials = 0;
      @(negedge clk);
      #1;
      checkOutput("mid_rst_hold_ready", {31'd0, wbck_if.longp_wbck_i_ready}, 32'd0);
      wbck_if.alu_wbck_i_valid = 1'b0; wbck_if.longp_wbck_i_valid = 1'b0;
      wbck_if.rf_wbck_o_ready = 1'b1;
      rst_n = 1'b1; in_reset = 1'b0;
      idleCycles(2);
      aluItem(32'hF000_0001, 5'd14, 1'b1);
      checkOutput("post_rst_alu_ready", {31'd0, last_alu_ready}, 32'd1);
      applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b1, 32'hF000_0002, 5'd15, 1'b0, 1'b1);
      idleCycles(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
